spi_frame_ctrl: RTL and testbench

SPI slave frame controller that sequences the on-chip register file (motor speed, park, bending, fan, fault and ready registers). It deserializes 32-bit mode-0 SPI frames from an external master and issues single register-bus write or read operations: `addr`, `wdata`, a one-cycle `wr` strobe, and registered `rdata` returned one `clk` later. Read data is serialized back on `miso` within the same frame. It sits between the chip pins and the register file, entirely in the `clk` domain.

---
 rtl/spi_frame_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_ctrl.sv
// SPI mode-0 slave that turns 32-bit frames into single register-bus reads/writes.
// Optional build macro SPI_FRAME_CTRL_ABORT_CNT_EN enables the saturating aborted-frame counter.
module spi_frame_ctrl #(
  parameter int unsigned SCLK_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic [15:0] addr,
  output logic [15:0] wdata,
  output logic        wr,
  input  logic [15:0] rdata,
  output logic        busy,
  output logic        xfer_done,
  output logic [7:0]  abort_cnt
);

  localparam int unsigned CNT_W      = 6;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned HALF_BITS  = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    RD_WAIT = 3'd2,
    RD_LOAD = 3'd3,
    RDATA   = 3'd4,
    WDATA   = 3'd5,
    DONE    = 3'd6
  } state_t;

  logic [SCLK_SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  // Pin synchronizers plus one extra flop for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SCLK_SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SCLK_SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SCLK_SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SCLK_SYNC_STAGES-1];
  assign cs_s      = cs_sync[SCLK_SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SCLK_SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [14:0]       rx_sr, rx_sr_nxt;   // only the last 15 bits are ever needed
  logic [14:0]       tx_sr, tx_sr_nxt;   // bits still to send after the one on miso
  logic [DATA_W-1:0] addr_nxt, wdata_nxt;
  logic              wr_nxt, done_nxt, miso_nxt, busy_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      addr      <= '0;
      wdata     <= '0;
      wr        <= 1'b0;
      xfer_done <= 1'b0;
      miso      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      rx_sr     <= rx_sr_nxt;
      tx_sr     <= tx_sr_nxt;
      addr      <= addr_nxt;
      wdata     <= wdata_nxt;
      wr        <= wr_nxt;
      xfer_done <= done_nxt;
      miso      <= miso_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    rx_sr_nxt   = rx_sr;
    tx_sr_nxt   = tx_sr;
    addr_nxt    = addr;
    wdata_nxt   = wdata;
    wr_nxt      = 1'b0;
    done_nxt    = 1'b0;
    miso_nxt    = miso;

    if (cs_rise && (state != IDLE)) begin
      // normal end of frame from DONE, abort from anywhere else
      state_nxt = IDLE;
      miso_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          miso_nxt = 1'b0;
          if (cs_fall) begin
            state_nxt   = CMD;
            bit_cnt_nxt = '0;
            rx_sr_nxt   = '0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            rx_sr_nxt   = {rx_sr[13:0], mosi_s};
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(HALF_BITS - 1)) begin
              addr_nxt  = {1'b0, rx_sr[13:0], mosi_s};
              state_nxt = rx_sr[14] ? WDATA : RD_WAIT;
            end
          end
        end
        RD_WAIT: state_nxt = RD_LOAD;
        RD_LOAD: begin
          tx_sr_nxt = rdata[14:0];
          miso_nxt  = rdata[15];
          state_nxt = RDATA;
        end
        RDATA: begin
          if (sclk_rise) begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
              miso_nxt  = 1'b0;
            end
          end else if (sclk_fall && (bit_cnt > CNT_W'(HALF_BITS))) begin
            // the fall right after the 16th rise must keep bit15 on the line
            miso_nxt  = tx_sr[14];
            tx_sr_nxt = {tx_sr[13:0], 1'b0};
          end
        end
        WDATA: begin
          if (sclk_rise) begin
            rx_sr_nxt   = {rx_sr[13:0], mosi_s};
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
              wdata_nxt = {rx_sr, mosi_s};
              wr_nxt    = 1'b1;
              done_nxt  = 1'b1;
              state_nxt = DONE;
            end
          end
        end
        DONE:    miso_nxt  = 1'b0;
        default: state_nxt = IDLE;
      endcase
    end

    busy_nxt = (state_nxt != IDLE);
  end

`ifdef SPI_FRAME_CTRL_ABORT_CNT_EN
  logic       abort;
  logic [7:0] abort_q;

  assign abort = cs_rise && (state != IDLE) && (state != DONE);

  // Saturating count of frames cut short by cs_n
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      abort_q <= '0;
    end else if (abort && (abort_q != 8'hFF)) begin
      abort_q <= abort_q + 8'd1;
    end
  end

  assign abort_cnt = abort_q;
`else
  assign abort_cnt = '0;
`endif

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Bench for spi_frame_ctrl: directed vector table, reset/saturation sequences and
// randomized frames checked against a register-level model of the frame rules.
module tb_spi_frame_ctrl;

  localparam int PH = 5;
`ifdef SPI_FRAME_CTRL_ABORT_CNT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn, sclk, cs_n, mosi, miso, wr, busy, xfer_done;
  logic [15:0] addr, wdata, rdata;
  logic [7:0]  abort_cnt;

  always #5 clk = ~clk;

  spi_frame_ctrl #(.SCLK_SYNC_STAGES(2)) dut (
    .clk(clk), .rstn(rstn), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .addr(addr), .wdata(wdata), .wr(wr), .rdata(rdata), .busy(busy),
    .xfer_done(xfer_done), .abort_cnt(abort_cnt)
  );

  // Register-file stand-in: 256 words, registered read data
  logic [15:0] regs [0:255];
  initial begin
    for (int i = 0; i < 256; i++) regs[i] = 16'h0;
    rdata = 16'h0;
  end
  always @(posedge clk) begin
    if (wr && (addr < 16'd256)) regs[addr[7:0]] <= wdata;
    rdata <= (addr < 16'd256) ? regs[addr[7:0]] : 16'h0;
  end

  int          wr_seen = 0, done_seen = 0, wr_wo_done = 0;
  logic [15:0] wr_addr = '0, wr_data = '0;
  always @(negedge clk) begin
    if (wr) begin
      wr_seen++;
      wr_addr = addr;
      wr_data = wdata;
      if (!xfer_done) wr_wo_done++;
    end
    if (xfer_done) done_seen++;
  end

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master side: mode 0, samples miso just before each rise; optional reset at bit rst_at
  task automatic spi_xfer(input logic [39:0] bits, input int nbits, input int rst_at,
                          output logic [31:0] rx, output int turn, output logic [43:0] snap);
    rx = '0; turn = -1; snap = '1;
    @(negedge clk);
    cs_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rstn = 1'b0;
        #1;
        snap = {addr, wdata, wr, miso, busy, xfer_done, abort_cnt};
        wait_clk(3);
        sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1;
        wait_clk(2);
        rstn = 1'b1;
        wait_clk(8);
        return;
      end
      mosi = bits[39-i];
      for (int k = 1; k <= PH; k++) begin
        @(negedge clk);
        if (i == 16 && turn < 0 && miso === 1'b1) turn = PH + k;
      end
      if (i < 32) rx[31-i] = miso;
      sclk = 1'b1;
      for (int k = 1; k <= PH; k++) begin
        @(negedge clk);
        if (i == 15 && turn < 0 && miso === 1'b1) turn = k;
      end
      sclk = 1'b0;
    end
    wait_clk(PH);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(8);
  endtask

  typedef struct {
    logic [39:0] bits;
    int          nbits;
    int          exp_wr;
    int          exp_done;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
    bit          chk_rd;
    logic [15:0] exp_rd;
    logic [7:0]  exp_abort;
    bit          chk_turn;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] f, input logic [7:0] ext, input int n,
                              input int ew, input int ed, input logic [15:0] ea,
                              input logic [15:0] ewd, input bit crd, input logic [15:0] erd,
                              input logic [7:0] eab, input bit ct);
    vec_t v;
    v.bits = {f, ext}; v.nbits = n; v.exp_wr = ew; v.exp_done = ed;
    v.exp_addr = ea; v.exp_wdata = ewd; v.chk_rd = crd; v.exp_rd = erd;
    v.exp_abort = eab; v.chk_turn = ct;
    return v;
  endfunction

  task automatic apply(input string tag, input vec_t v);
    int w0, d0, x0, turn;
    logic [31:0] rx;
    logic [43:0] snap;
    w0 = wr_seen; d0 = done_seen; x0 = wr_wo_done;
    spi_xfer(v.bits, v.nbits, -1, rx, turn, snap);
    chk({tag, ".wr_pulses"}, 32'(wr_seen - w0), 32'(v.exp_wr));
    chk({tag, ".done_pulses"}, 32'(done_seen - d0), 32'(v.exp_done));
    chk({tag, ".addr"}, 32'(addr), 32'(v.exp_addr));
    chk({tag, ".wdata"}, 32'(wdata), 32'(v.exp_wdata));
    chk({tag, ".abort_cnt"}, 32'(abort_cnt), 32'(v.exp_abort));
    chk({tag, ".busy_after"}, 32'(busy), 32'd0);
    if (v.exp_wr > 0) begin
      chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(v.exp_addr));
      chk({tag, ".wr_data"}, 32'(wr_data), 32'(v.exp_wdata));
      chk({tag, ".wr_with_done"}, 32'(wr_wo_done - x0), 32'd0);
    end
    if (v.chk_rd) chk({tag, ".readback"}, 32'(rx[15:0]), 32'(v.exp_rd));
    if (v.chk_turn) begin
      vectors++;
      if (turn < 1 || turn > 6) begin
        miscompares++;
        $display("FAIL %s.turnaround: got %0d clk expected 1..6 clk", tag, turn);
      end
    end
  endtask

  // Reference model: register contents and bus outputs as implied by the frame rules
  logic [15:0] m_mem [int];
  logic [15:0] m_addr, m_wdata;
  logic [7:0]  m_abort;

  task automatic model_step(input logic [31:0] frame, input int nbits, input logic [7:0] ext,
                            output vec_t v);
    logic [15:0] a;
    a = {1'b0, frame[30:16]};
    v.bits = {frame, ext}; v.nbits = nbits; v.chk_turn = 1'b0;
    v.exp_wr = 0; v.exp_done = 0; v.chk_rd = 1'b0; v.exp_rd = '0;
    if (nbits >= 16) m_addr = a;
    if (nbits >= 32) begin
      v.exp_done = 1;
      if (frame[31]) begin
        v.exp_wr = 1;
        m_wdata = frame[15:0];
        if (a < 16'd256) m_mem[int'(a)] = frame[15:0];
      end else begin
        v.chk_rd = 1'b1;
        v.exp_rd = m_mem.exists(int'(a)) ? m_mem[int'(a)] : 16'h0;
      end
    end else if (ABORT_EN && m_abort != 8'hFF) begin
      m_abort = m_abort + 8'd1;
    end
    v.exp_addr = m_addr; v.exp_wdata = m_wdata; v.exp_abort = m_abort;
  endtask

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [10];
    vec_t        v;
    logic [7:0]  ab;
    logic [31:0] rx, frame;
    logic [43:0] snap;
    int          turn, w0, d0, nb, r;
    logic [14:0] a15;

    ab = 8'(ABORT_EN);
    tbl[0] = mk(32'h8000_1234, 8'h00, 32, 1, 1, 16'h0000, 16'h1234, 0, 16'h0, 8'h0, 0);
    tbl[1] = mk(32'h0000_0000, 8'h00, 32, 0, 1, 16'h0000, 16'h1234, 1, 16'h1234, 8'h0, 0);
    tbl[2] = mk(32'h8002_0001, 8'h00, 32, 1, 1, 16'h0002, 16'h0001, 0, 16'h0, 8'h0, 0);
    tbl[3] = mk(32'h0002_0000, 8'h00, 32, 0, 1, 16'h0002, 16'h0001, 1, 16'h0001, 8'h0, 0);
    tbl[4] = mk(32'h0007_0000, 8'h00, 32, 0, 1, 16'h0007, 16'h0001, 1, 16'h0000, 8'h0, 0);
    tbl[5] = mk(32'h8001_0001, 8'h00, 10, 0, 0, 16'h0007, 16'h0001, 0, 16'h0, ab, 0);
    tbl[6] = mk(32'h8001_0001, 8'hFF, 40, 1, 1, 16'h0001, 16'h0001, 0, 16'h0, ab, 0);
    tbl[7] = mk(32'h8005_A5A5, 8'h00, 32, 1, 1, 16'h0005, 16'hA5A5, 0, 16'h0, ab, 0);
    tbl[8] = mk(32'h0005_0000, 8'h00, 32, 0, 1, 16'h0005, 16'hA5A5, 1, 16'hA5A5, ab, 1);
    tbl[9] = mk(32'h0001_0000, 8'hAA, 40, 0, 1, 16'h0001, 16'hA5A5, 1, 16'h0001, ab, 0);

    rstn = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    wait_clk(3);
    chk("reset.addr", 32'(addr), 32'd0);
    chk("reset.wdata", 32'(wdata), 32'd0);
    chk("reset.wr", 32'(wr), 32'd0);
    chk("reset.miso", 32'(miso), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.xfer_done", 32'(xfer_done), 32'd0);
    chk("reset.abort_cnt", 32'(abort_cnt), 32'd0);
    rstn = 1'b1;
    wait_clk(3);

    for (int i = 0; i < 10; i++) apply($sformatf("vec%0d", i), tbl[i]);

    // Reset in the middle of a write frame, then confirm the bus comes back cleanly
    w0 = wr_seen; d0 = done_seen;
    spi_xfer({32'h8003_BEEF, 8'h00}, 32, 24, rx, turn, snap);
    chk("midrst.outputs_at_reset", 32'(snap == 44'h0), 32'd1);
    chk("midrst.wr_pulses", 32'(wr_seen - w0), 32'd0);
    chk("midrst.done_pulses", 32'(done_seen - d0), 32'd0);
    apply("midrst.read_after", mk(32'h0003_0000, 8'h00, 32, 0, 1, 16'h0003, 16'h0000, 1, 16'h0000, 8'h0, 0));
    apply("midrst.write_after", mk(32'h8003_0042, 8'h00, 32, 1, 1, 16'h0003, 16'h0042, 0, 16'h0, 8'h0, 0));

    m_mem[0] = 16'h1234; m_mem[1] = 16'h0001; m_mem[2] = 16'h0001;
    m_mem[3] = 16'h0042; m_mem[5] = 16'hA5A5;
    m_addr = 16'h0003; m_wdata = 16'h0042; m_abort = 8'h0;

    for (int i = 0; i < 40; i++) begin
      a15 = ($urandom_range(0, 9) == 0) ? 15'(16'h4000 + $urandom_range(0, 255)) : 15'($urandom_range(0, 15));
      frame = {1'($urandom_range(0, 1)), a15, 16'($urandom)};
      r = $urandom_range(0, 9);
      nb = (r == 0) ? $urandom_range(0, 31) : (r == 1) ? $urandom_range(33, 40) : 32;
      model_step(frame, nb, 8'($urandom), v);
      apply($sformatf("rnd%0d", i), v);
    end

    // Enough aborts to push the counter past saturation
    for (int i = 0; i < 260; i++) begin
      model_step(32'h0, 0, 8'h0, v);
      spi_xfer(40'h0, 0, -1, rx, turn, snap);
    end
    chk("sat.abort_cnt_model", 32'(abort_cnt), 32'(m_abort));
    chk("sat.abort_cnt_limit", 32'(abort_cnt), ABORT_EN ? 32'd255 : 32'd0);
    apply("sat.frame_after", mk(32'h8004_5678, 8'h00, 32, 1, 1, 16'h0004, 16'h5678, 0, 16'h0, m_abort, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
